// File: rtl/spi_slave_rx.sv
// Oversampling SPI (mode 0) receiver: decodes SCK/SDI/CSX/DC into bytes with DC and first-of-frame flags.
// Define SPI_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FWFT FIFO.
`timescale 1ns/1ps

module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SCK,
    input  logic       SDI,
    input  logic       CSX,
    input  logic       DC,
    output logic [7:0] out_data,
    output logic       out_dc,
    output logic       out_first,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_active,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    // Bit order in each sync stage: {DC, CSX, SDI, SCK}; CSX idles high.
    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0] w_pins;
    logic [3:0] w_sync;
    logic       r_sck_d, r_csx_d;
    logic       r_sck_rise, r_cs_fall, r_cs_rise, r_sdi_q, r_dc_q;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_first_pending;
    logic       r_push, r_push_dc, r_push_first, r_ferr_set;
    logic [7:0] r_push_data;

    logic       w_ovr_set;
    logic       r_frame_err, r_overrun;

    assign w_pins       = {DC, CSX, SDI, SCK};
    assign w_sync       = r_sync[SYNC_STAGES-1];
    assign frame_active = ~w_sync[2];
    assign frame_err    = r_frame_err;
    assign overrun      = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= {SYNC_STAGES{4'b0100}};
            r_sck_d    <= 1'b0;
            r_csx_d    <= 1'b1;
            r_sck_rise <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_cs_rise  <= 1'b0;
            r_sdi_q    <= 1'b0;
            r_dc_q     <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], w_pins};
            r_sck_d    <= w_sync[0];
            r_csx_d    <= w_sync[2];
            r_sck_rise <= w_sync[0] & ~r_sck_d;
            r_cs_fall  <= ~w_sync[2] & r_csx_d;
            r_cs_rise  <= w_sync[2] & ~r_csx_d;
            r_sdi_q    <= w_sync[1];
            r_dc_q     <= w_sync[3];
        end
    end

    // A CSX fall restarts the frame even if an SCK edge lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_bit_cnt       <= 3'd0;
            r_shift         <= 7'd0;
            r_first_pending <= 1'b0;
            r_push          <= 1'b0;
            r_push_data     <= 8'd0;
            r_push_dc       <= 1'b0;
            r_push_first    <= 1'b0;
            r_ferr_set      <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_ferr_set <= 1'b0;
            if (r_cs_fall) begin
                r_state         <= S_SHIFT;
                r_bit_cnt       <= 3'd0;
                r_first_pending <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_SHIFT: begin
                        if (r_cs_rise) begin
                            r_state   <= S_IDLE;
                            r_bit_cnt <= 3'd0;
                            if (r_bit_cnt != 3'd0)
                                r_ferr_set <= 1'b1;
                        end else if (r_sck_rise) begin
                            r_shift   <= {r_shift[5:0], r_sdi_q};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_push          <= 1'b1;
                                r_push_data     <= {r_shift, r_sdi_q};
                                r_push_dc       <= r_dc_q;
                                r_push_first    <= r_first_pending;
                                r_first_pending <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SPI_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        w_empty, w_full, w_pop, w_wr;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = ~w_empty & out_ready;
    assign w_wr      = r_push & (~w_full | w_pop);
    assign w_ovr_set = r_push & w_full & ~w_pop;

    assign {out_data, out_dc, out_first} = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid = ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= 10'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {r_push_data, r_push_dc, r_push_first};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
`else
    logic [7:0] r_hold_data;
    logic       r_hold_dc, r_hold_first, r_hold_valid;

    assign out_data  = r_hold_data;
    assign out_dc    = r_hold_dc;
    assign out_first = r_hold_first;
    assign out_valid = r_hold_valid;
    assign w_ovr_set = r_push & r_hold_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data  <= 8'd0;
            r_hold_dc    <= 1'b0;
            r_hold_first <= 1'b0;
            r_hold_valid <= 1'b0;
        end else if (r_push && (!r_hold_valid || out_ready)) begin
            r_hold_data  <= r_push_data;
            r_hold_dc    <= r_push_dc;
            r_hold_first <= r_push_first;
            r_hold_valid <= 1'b1;
        end else if (r_hold_valid && out_ready) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    // New errors take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= r_ferr_set | (r_frame_err & ~clr_err);
            r_overrun   <= w_ovr_set | (r_overrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a queue model of delivered bytes and sticky flags checked every cycle,
// plus literal expectations per scenario. Honours SPI_RX_FIFO_EN for the backpressure scenario.
`timescale 1ns/1ps

module tb_spi_slave_rx;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       SCK = 1'b0, SDI = 1'b0, CSX = 1'b1, DC = 1'b0;
    logic       out_ready = 1'b0, clr_err = 1'b0;
    logic [7:0] out_data;
    logic       out_dc, out_first, out_valid, frame_active, frame_err, overrun;

`ifdef SPI_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif
    // Pin sample edge to output edge, and to frame_active edge.
    localparam int LAT_OUT = 4;
    localparam int LAT_FA  = 1;

    spi_slave_rx #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .SCK(SCK), .SDI(SDI), .CSX(CSX), .DC(DC),
        .out_data(out_data), .out_dc(out_dc), .out_first(out_first), .out_valid(out_valid),
        .out_ready(out_ready), .frame_active(frame_active), .frame_err(frame_err),
        .overrun(overrun), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int kind; logic [7:0] d; logic dc; logic fr;} ev_t;
    typedef struct {logic [7:0] d; logic dc; logic fr;} rec_t;

    ev_t  evq[$];
    rec_t mq[$];
    rec_t acc[$];
    int   n_chk = 0, n_err = 0, cyc = 0;
    logic m_ferr = 1'b0, m_ovr = 1'b0, m_fa = 1'b0, cmp_en = 1'b0;
    int   m_bits = 0;
    logic [7:0] m_sh = 8'h00;
    logic m_first = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic add_ev(input int due, input int kind, input logic [7:0] d, input logic dc, input logic fr);
        ev_t e;
        e.due = due; e.kind = kind; e.d = d; e.dc = dc; e.fr = fr;
        evq.push_back(e);
    endtask

    task automatic chk_acc(input string name, input int k, input logic [7:0] d, input logic dc, input logic fr);
        if (acc.size() > k) begin
            chk({name, "_data"}, acc[k].d, d);
            chk({name, "_dc"}, acc[k].dc, dc);
            chk({name, "_first"}, acc[k].fr, fr);
        end else begin
            chk({name, "_present"}, 0, 1);
        end
    endtask

    // Model: bytes become visible LAT_OUT edges after the pin sample, queue holds CAP entries.
    initial begin : model
        ev_t  e;
        rec_t r;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                mq.delete(); evq.delete();
                m_ferr = 1'b0; m_ovr = 1'b0; m_fa = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    r.d = out_data; r.dc = out_dc; r.fr = out_first;
                    acc.push_back(r);
                    $display("rx byte=%02h dc=%0b first=%0b cycle=%0d", r.d, r.dc, r.fr, cyc);
                end
                if (mq.size() > 0 && out_ready)
                    void'(mq.pop_front());
                if (clr_err) begin
                    m_ferr = 1'b0; m_ovr = 1'b0;
                end
                while (evq.size() > 0 && evq[0].due <= cyc) begin
                    e = evq.pop_front();
                    case (e.kind)
                        0: begin
                            if (mq.size() < CAP) begin
                                r.d = e.d; r.dc = e.dc; r.fr = e.fr;
                                mq.push_back(r);
                            end else begin
                                m_ovr = 1'b1;
                            end
                        end
                        1: m_ferr = 1'b1;
                        default: m_fa = e.dc;
                    endcase
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && cmp_en) begin
                chk("valid", out_valid, mq.size() != 0);
                if (mq.size() != 0) begin
                    chk("data", out_data, mq[0].d);
                    chk("dc", out_dc, mq[0].dc);
                    chk("first", out_first, mq[0].fr);
                end
                chk("overrun", overrun, m_ovr);
                chk("frame_err", frame_err, m_ferr);
                chk("frame_active", frame_active, m_fa);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        CSX = 1'b0;
        add_ev(cyc + 1 + LAT_FA, 2, 8'h00, 1'b1, 1'b0);
        m_bits = 0;
        m_first = 1'b1;
        wait_n(6);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            SDI = b[7-i];
            DC  = dc;
            wait_n(3);
            SCK = 1'b1;
            m_sh = {m_sh[6:0], b[7-i]};
            m_bits++;
            if (m_bits % 8 == 0) begin
                add_ev(cyc + 1 + LAT_OUT, 0, m_sh, dc, m_first);
                m_first = 1'b0;
            end
            wait_n(4);
            SCK = 1'b0;
        end
    endtask

    task automatic cs_high();
        wait_n(2);
        @(negedge clk);
        CSX = 1'b1;
        add_ev(cyc + 1 + LAT_FA, 2, 8'h00, 1'b0, 1'b0);
        if (m_bits % 8 != 0)
            add_ev(cyc + 1 + LAT_OUT, 1, 8'h00, 1'b0, 1'b0);
        wait_n(10);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_out_dc"}, out_dc, 0);
        chk({name, "_out_first"}, out_first, 0);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_frame_active"}, frame_active, 0);
        chk({name, "_frame_err"}, frame_err, 0);
        chk({name, "_overrun"}, overrun, 0);
    endtask

    initial begin : stim
        wait_n(4);
        chk_all_zero("reset");
        rst_n = 1'b1;
        wait_n(3);
        cmp_en = 1'b1;

        // Single byte frame
        out_ready = 1'b1;
        cs_low();
        chk("fa_in_frame", frame_active, 1);
        send_bits(8'hA5, 1'b0, 8);
        cs_high();
        chk("single_count", acc.size(), 1);
        chk_acc("single", 0, 8'hA5, 1'b0, 1'b1);
        chk("single_ferr", frame_err, 0);
        acc.delete();

        // Two-byte frame, DC=1 on the second byte
        cs_low();
        send_bits(8'hA5, 1'b0, 8);
        send_bits(8'h5A, 1'b1, 8);
        cs_high();
        chk("two_count", acc.size(), 2);
        chk_acc("two_b0", 0, 8'hA5, 1'b0, 1'b1);
        chk_acc("two_b1", 1, 8'h5A, 1'b1, 1'b0);
        acc.delete();

        // Abort after 5 bits, clear, then a clean byte
        cs_low();
        send_bits(8'hF0, 1'b0, 5);
        cs_high();
        chk("abort_ferr", frame_err, 1);
        chk("abort_count", acc.size(), 0);
        pulse_clr();
        wait_n(1);
        chk("abort_cleared", frame_err, 0);
        cs_low();
        send_bits(8'h3C, 1'b0, 8);
        cs_high();
        chk("after_abort_count", acc.size(), 1);
        chk_acc("after_abort", 0, 8'h3C, 1'b0, 1'b1);
        acc.delete();

        // Backpressure
        out_ready = 1'b0;
        cs_low();
`ifdef SPI_RX_FIFO_EN
        for (int k = 1; k <= 5; k++)
            send_bits(8'(k), 1'b0, 8);
        cs_high();
        chk("bp_overrun", overrun, 1);
        chk("bp_held_head", out_data, 8'h01);
        @(negedge clk);
        out_ready = 1'b1;
        wait_n(8);
        chk("bp_count", acc.size(), 4);
        for (int k = 0; k < 4; k++)
            chk_acc("bp_drain", k, 8'(k + 1), 1'b0, (k == 0));
        chk("bp_empty", out_valid, 0);
`else
        send_bits(8'h11, 1'b0, 8);
        send_bits(8'h22, 1'b0, 8);
        cs_high();
        chk("bp_held_data", out_data, 8'h11);
        chk("bp_held_first", out_first, 1);
        chk("bp_overrun", overrun, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        wait_n(1);
        chk("bp_empty", out_valid, 0);
        chk("bp_count", acc.size(), 1);
        chk_acc("bp_pop", 0, 8'h11, 1'b0, 1'b1);
        out_ready = 1'b1;
`endif
        acc.delete();

        // Reset mid-byte; overrun is still set from the previous scenario
        cs_low();
        send_bits(8'hFF, 1'b1, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        CSX = 1'b1;
        SCK = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(5);
        cs_low();
        send_bits(8'hC3, 1'b1, 8);
        cs_high();
        chk("post_reset_count", acc.size(), 1);
        chk_acc("post_reset", 0, 8'hC3, 1'b1, 1'b1);
        chk("post_reset_ferr", frame_err, 0);

        wait_n(20);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
